// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the weight-stationary MAC array.
// PE_ARRAY_SAT_EN selects saturating accumulation in pe_mac.
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    function automatic int lat(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // Operands arrive sign-extended from acc_w bits, so the wide sum never overflows.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] sum_v;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sum_v = a + b;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum_v > max_v) begin
            return max_v;
        end else if (sum_v < min_v) begin
            return min_v;
        end else begin
            return sum_v;
        end
    endfunction

endpackage

// File: rtl/pe_array_ws_mac.sv
// Single weight-stationary PE: registers psum_in + x*w and forwards x.
// PE_ARRAY_SAT_EN clamps the accumulate instead of wrapping.
module pe_mac
    import pe_array_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [DATA_W-1:0] x_out,
    output logic [ACC_W-1:0]  psum_out
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0]        acc_d;
    logic [DATA_W-1:0]       x_q;
    logic [ACC_W-1:0]        psum_q;

    assign prod_s     = PW'($signed(x_in)) * PW'($signed(w));
    assign prod_ext_s = ACC_W'(prod_s);

`ifdef PE_ARRAY_SAT_EN
    assign acc_d = ACC_W'(sat_add(SAT_W'($signed(psum_in)), SAT_W'(prod_ext_s), ACC_W));
`else
    assign acc_d = ACC_W'($signed(psum_in) + prod_ext_s);
`endif

    // Operand and partial-sum registers, frozen while the array is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            psum_q <= '0;
        end else if (en) begin
            x_q    <= x_in;
            psum_q <= acc_d;
        end
    end

    assign x_out    = x_q;
    assign psum_out = psum_q;

endmodule

// File: rtl/pe_array_ws.sv
// Weight-stationary systolic MAC array with weight-load phase and control FSM.
// Optional macro PE_ARRAY_SAT_EN: saturating accumulation inside every PE.
module pe_array_ws
    import pe_array_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [NUM_COLS*DATA_W-1:0]   w_data,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic [NUM_ROWS*DATA_W-1:0]   x_data,
    input  logic                         x_last,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic [NUM_COLS*ACC_W-1:0]    y_data,
    output logic                         y_last,
    output logic                         busy
);

    localparam int LAT    = lat(NUM_ROWS, NUM_COLS);
    localparam int WCNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   w_q [NUM_ROWS][NUM_COLS];
    logic [LAT-1:0]      vld_q;
    logic [LAT-1:0]      lst_q;

    logic                en_s;
    logic                w_hs_s;
    logic                x_hs_s;
    logic [DATA_W-1:0]   x_inj_s        [NUM_ROWS];
    logic [DATA_W-1:0]   x_link_s       [NUM_ROWS][NUM_COLS+1];
    logic [DATA_W-1:0]   x_edge_unused_s [NUM_ROWS];
    logic [ACC_W-1:0]    psum_link_s    [NUM_ROWS+1][NUM_COLS];
    logic [ACC_W-1:0]    y_col_s        [NUM_COLS];

    assign en_s    = y_ready | ~vld_q[LAT-1];
    assign w_ready = (state_q == LOAD_W);
    assign x_ready = en_s & (state_q == COMPUTE);
    assign busy    = (state_q != IDLE);
    assign w_hs_s  = w_valid & w_ready;
    assign x_hs_s  = x_valid & x_ready;
    assign y_valid = vld_q[LAT-1];
    assign y_last  = lst_q[LAT-1];

    // State and weight-row counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic for the tile sequencer.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD_W;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (w_hs_s) begin
                    if (wcnt_q == WCNT_W'(NUM_ROWS - 1)) begin
                        wcnt_d  = '0;
                        state_d = COMPUTE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            COMPUTE: begin
                if (x_hs_s && x_last) begin
                    state_d = DRAIN;
                end else begin
                    state_d = COMPUTE;
                end
            end
            DRAIN: begin
                if (vld_q[LAT-1] && y_ready && lst_q[LAT-1]) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // Weight storage: one row per accepted beat, retained across tiles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else if (w_hs_s) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (wcnt_q == WCNT_W'(r)) begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        w_q[r][c] <= w_data[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // An enabled cycle without a handshake injects a zero bubble.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (x_hs_s) begin
                x_inj_s[r] = x_data[r*DATA_W +: DATA_W];
            end else begin
                x_inj_s[r] = '0;
            end
        end
    end

    // Valid/last travel alongside the data wavefront.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (en_s) begin
            vld_q[0] <= x_hs_s;
            lst_q[0] <= x_hs_s & x_last;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign x_link_s[r][0] = x_inj_s[r];
        end else begin : g_regs
            logic [DATA_W-1:0] sk_q [r];
            // Row r is delayed r cycles so it meets the psum arriving from above.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) begin
                        sk_q[i] <= '0;
                    end
                end else if (en_s) begin
                    sk_q[0] <= x_inj_s[r];
                    for (int i = 1; i < r; i++) begin
                        sk_q[i] <= sk_q[i-1];
                    end
                end
            end
            assign x_link_s[r][0] = sk_q[r-1];
        end
        assign x_edge_unused_s[r] = x_link_s[r][NUM_COLS];
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_top
        assign psum_link_s[0][c] = '0;
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            pe_mac #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en       (en_s),
                .x_in     (x_link_s[r][c]),
                .w        (w_q[r][c]),
                .psum_in  (psum_link_s[r][c]),
                .x_out    (x_link_s[r][c+1]),
                .psum_out (psum_link_s[r+1][c])
            );
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_deskew
        localparam int D = NUM_COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign y_col_s[c] = psum_link_s[NUM_ROWS][c];
        end else begin : g_regs
            logic [ACC_W-1:0] dk_q [D];
            // Left columns finish early and wait here so the whole vector aligns.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        dk_q[i] <= '0;
                    end
                end else if (en_s) begin
                    dk_q[0] <= psum_link_s[NUM_ROWS][c];
                    for (int i = 1; i < D; i++) begin
                        dk_q[i] <= dk_q[i-1];
                    end
                end
            end
            assign y_col_s[c] = dk_q[D-1];
        end
        assign y_data[c*ACC_W +: ACC_W] = y_col_s[c];
    end

endmodule

// File: tb/tb_pe_array_ws.sv
// Directed, table-driven bench for pe_array_ws (3x3, plus a 16-bit accumulator instance).
module tb_pe_array_ws;

    logic clk = 1'b0;
    logic rst;
    logic cfg_start, w_valid, w_ready, x_valid, x_ready, x_last;
    logic y_valid, y_ready, y_last, busy;
    logic [23:0] w_data, x_data;
    logic [71:0] y_data;

    logic b_cfg_start, b_w_valid, b_w_ready, b_x_valid, b_x_ready, b_x_last;
    logic b_y_valid, b_y_ready, b_y_last, b_busy;
    logic [23:0] b_w_data, b_x_data;
    logic [47:0] b_y_data;

`ifdef PE_ARRAY_SAT_EN
    localparam logic [15:0] T5_EXP = 16'h7FFF;
`else
    localparam logic [15:0] T5_EXP = 16'hC000;
`endif

    typedef struct {
        logic [2:0][7:0]  x;
        logic             last;
        int               gap;
        logic [2:0][23:0] y;
    } vec_t;

    vec_t tbl [15];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [71:0] got_q[$];
    logic        got_last_q[$];
    int          ycyc_q[$];
    int          hs_q[$];

    always #5 clk = ~clk;

    pe_array_ws u_dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .busy(busy)
    );

    pe_array_ws #(.DATA_W(8), .ACC_W(16), .NUM_ROWS(3), .NUM_COLS(3)) u_dut16 (
        .clk(clk), .rst(rst), .cfg_start(b_cfg_start),
        .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
        .x_valid(b_x_valid), .x_ready(b_x_ready), .x_data(b_x_data), .x_last(b_x_last),
        .y_valid(b_y_valid), .y_ready(b_y_ready), .y_data(b_y_data), .y_last(b_y_last),
        .busy(b_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are visible at the negedge before the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (y_valid && y_ready) begin
                got_q.push_back(y_data);
                got_last_q.push_back(y_last);
                ycyc_q.push_back(cyc);
            end
            if (x_valid && x_ready) hs_q.push_back(cyc);
        end
    end

    function automatic logic [2:0][7:0] xv(input int a, input int b, input int c);
        xv = {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [2:0][23:0] yv(input int a, input int b, input int c);
        yv = {24'(c), 24'(b), 24'(a)};
    endfunction

    function automatic logic [2:0][2:0][7:0] w_ident();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_ident[r][c] = (r == c) ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [2:0][2:0][7:0] w_rc();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_rc[r][c] = 8'(r + c + 1);
    endfunction

    task automatic set_v(input int i, input logic [2:0][7:0] x, input logic l,
                         input int g, input logic [2:0][23:0] y);
        tbl[i].x = x; tbl[i].last = l; tbl[i].gap = g; tbl[i].y = y;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no DUT response want handshake/valid", nm);
    endtask

    task automatic clear_q();
        got_q.delete(); got_last_q.delete(); ycyc_q.delete(); hs_q.delete();
    endtask

    task automatic load_w(input logic [2:0][2:0][7:0] wm);
        logic hs;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_valid = 1'b1;
            w_data  = wm[k];
            hs = 1'b0;
            for (int n = 0; n < 20 && !hs; n++) begin
                @(negedge clk); hs = w_ready;
                @(posedge clk); #1;
            end
            if (!hs) fail("w_timeout");
        end
        w_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        logic hs;
        for (int i = lo; i <= hi; i++) begin
            x_valid = 1'b1;
            x_data  = tbl[i].x;
            x_last  = tbl[i].last;
            hs = 1'b0;
            for (int n = 0; n < 200 && !hs; n++) begin
                @(negedge clk); hs = x_ready;
                @(posedge clk); #1;
            end
            x_valid = 1'b0;
            x_last  = 1'b0;
            if (!hs) fail($sformatf("x_timeout_%0d", i));
            repeat (tbl[i].gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic check_range(input int lo, input int hi, input string tag);
        int n;
        n = hi - lo + 1;
        for (int k = 0; k < 200 && got_q.size() < n; k++) begin @(posedge clk); #1; end
        repeat (8) begin @(posedge clk); #1; end
        chk({tag, "_count"}, 128'(got_q.size()), 128'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_y%0d", tag, i), 128'(got_q[i]), 128'(tbl[lo+i].y));
                chk($sformatf("%s_last%0d", tag, i), 128'(got_last_q[i]), 128'(tbl[lo+i].last));
            end
        end
        chk({tag, "_busy_idle"}, 128'(busy), 128'd0);
    endtask

    task automatic stall();
        for (int k = 0; k < 100 && !y_valid; k++) begin @(posedge clk); #1; end
        y_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_stall_x_ready", 128'(x_ready), 128'd0);
            chk("t3_stall_y_valid", 128'(y_valid), 128'd1);
            @(posedge clk); #1;
        end
        y_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; w_valid = 1'b0; w_data = '0;
        x_valid = 1'b0; x_data = '0; x_last = 1'b0; y_ready = 1'b1;
        b_cfg_start = 1'b0; b_w_valid = 1'b0; b_w_data = '0;
        b_x_valid = 1'b0; b_x_data = '0; b_x_last = 1'b0; b_y_ready = 1'b1;

        set_v(0,  xv(1, 2, 3),       1'b1, 0, yv(1, 2, 3));
        set_v(1,  xv(1, 1, 1),       1'b0, 0, yv(6, 9, 12));
        set_v(2,  xv(2, 0, 0),       1'b0, 0, yv(2, 4, 6));
        set_v(3,  xv(0, 0, -1),      1'b0, 0, yv(-3, -4, -5));
        set_v(4,  xv(127, 127, 127), 1'b1, 0, yv(762, 1143, 1524));
        set_v(5,  xv(1, 1, 1),       1'b0, 0, yv(6, 9, 12));
        set_v(6,  xv(2, 0, 0),       1'b0, 0, yv(2, 4, 6));
        set_v(7,  xv(0, 0, -1),      1'b0, 0, yv(-3, -4, -5));
        set_v(8,  xv(127, 127, 127), 1'b0, 0, yv(762, 1143, 1524));
        set_v(9,  xv(1, 2, 3),       1'b0, 0, yv(14, 20, 26));
        set_v(10, xv(-1, -1, -1),    1'b1, 0, yv(-6, -9, -12));
        set_v(11, xv(1, 1, 1),       1'b0, 2, yv(6, 9, 12));
        set_v(12, xv(2, 0, 0),       1'b0, 2, yv(2, 4, 6));
        set_v(13, xv(0, 0, -1),      1'b1, 0, yv(-3, -4, -5));
        set_v(14, xv(1, 1, 1),       1'b1, 0, yv(6, 9, 12));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w_ready", 128'(w_ready), 128'd0);
        chk("rst_x_ready", 128'(x_ready), 128'd0);
        chk("rst_y_valid", 128'(y_valid), 128'd0);
        chk("rst_y_last",  128'(y_last),  128'd0);
        chk("rst_y_data",  128'(y_data),  128'd0);
        chk("rst_busy",    128'(busy),    128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Weight and ifmap traffic in IDLE must be refused.
        w_valid = 1'b1; w_data = 24'hABCDEF; x_valid = 1'b1; x_data = xv(5, 5, 5);
        @(negedge clk);
        chk("idle_w_ready", 128'(w_ready), 128'd0);
        chk("idle_x_ready", 128'(x_ready), 128'd0);
        chk("idle_busy",    128'(busy),    128'd0);
        @(posedge clk); #1;
        w_valid = 1'b0; x_valid = 1'b0;

        // T1: identity weights, single vector, latency.
        load_w(w_ident());
        clear_q();
        @(negedge clk);
        chk("t1_x_ready", 128'(x_ready), 128'd1);
        chk("t1_busy",    128'(busy),    128'd1);
        @(posedge clk); #1;
        send_range(0, 0);
        check_range(0, 0, "t1");
        if (ycyc_q.size() > 0 && hs_q.size() > 0)
            chk("t1_latency", 128'(ycyc_q[0] - hs_q[0]), 128'd5);
        else
            fail("t1_latency");

        // T2: back-to-back stream; stray cfg_start/w_valid in COMPUTE ignored.
        load_w(w_rc());
        clear_q();
        cfg_start = 1'b1; w_valid = 1'b1; w_data = 24'h7F7F7F;
        @(negedge clk);
        chk("t2_compute_w_ready", 128'(w_ready), 128'd0);
        @(posedge clk); #1;
        cfg_start = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        chk("t2_still_compute", 128'(x_ready), 128'd1);
        @(posedge clk); #1;
        send_range(1, 4);
        check_range(1, 4, "t2");
        for (int i = 1; i < 4; i++)
            if (i < ycyc_q.size())
                chk($sformatf("t2_rate%0d", i), 128'(ycyc_q[i] - ycyc_q[i-1]), 128'd1);

        // T3: downstream stall mid-stream.
        load_w(w_rc());
        clear_q();
        fork
            send_range(5, 10);
            stall();
        join
        check_range(5, 10, "t3");

        // T4: gaps between vectors.
        load_w(w_rc());
        clear_q();
        send_range(11, 13);
        check_range(11, 13, "t4");

        // T5: 16-bit accumulator overflow on the second instance.
        b_cfg_start = 1'b1;
        @(posedge clk); #1;
        b_cfg_start = 1'b0;
        b_w_valid = 1'b1; b_w_data = {3{8'h80}};
        @(negedge clk);
        chk("t5_w_ready", 128'(b_w_ready), 128'd1);
        repeat (3) begin @(posedge clk); #1; end
        b_w_valid = 1'b0;
        b_x_valid = 1'b1; b_x_data = {3{8'h80}}; b_x_last = 1'b1;
        @(negedge clk);
        chk("t5_x_ready", 128'(b_x_ready), 128'd1);
        @(posedge clk); #1;
        b_x_valid = 1'b0; b_x_last = 1'b0;
        for (int k = 0; k < 20 && !b_y_valid; k++) begin @(posedge clk); #1; end
        if (!b_y_valid) fail("t5_y_timeout");
        @(negedge clk);
        for (int c = 0; c < 3; c++)
            chk($sformatf("t5_y%0d", c), 128'(b_y_data[c*16 +: 16]), 128'(T5_EXP));
        chk("t5_last", 128'(b_y_last), 128'd1);
        @(posedge clk); #1;

        // T6: reset during DRAIN, then a clean tile.
        load_w(w_ident());
        clear_q();
        send_range(0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_busy_drain", 128'(busy), 128'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_y_valid", 128'(y_valid), 128'd0);
        chk("t6_rst_busy",    128'(busy),    128'd0);
        chk("t6_rst_y_data",  128'(y_data),  128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("t6_no_output", 128'(got_q.size()), 128'd0);
        load_w(w_rc());
        clear_q();
        send_range(14, 14);
        check_range(14, 14, "t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200000");
        $fatal(1);
    end

endmodule
